// File: rtl/rwc_pkg.sv
// Shared FSM encoding, width defaults and helpers for the rwc challenge scheduler.
package rwc_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;

   localparam logic [DATA_W_DEF-1:0] CHALLENGE_CLEAR = '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_LO,
      S_WAIT_HI,
      S_ACCUM,
      S_EMIT,
      S_DONE,
      S_ERR
   } rwc_state_t;

   function automatic int cnt_w(input int rep);
      return $clog2(rep + 1);
   endfunction

endpackage

// File: rtl/rwc_vote_acc.sv
// Per-bit vote counters; majority and (with RWC_SCHED_UNSTABLE_EN) unstable flags.
module rwc_vote_acc
   import rwc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REPEAT = 5
) (
   input  logic              clk,
   input  logic              w_resetn,
   input  logic              clr,
   input  logic              acc,
   input  logic [DATA_W-1:0] bits,
   output logic [DATA_W-1:0] maj
`ifdef RWC_SCHED_UNSTABLE_EN
   ,
   output logic [DATA_W-1:0] unstable
`endif
);

   localparam int CW = cnt_w(REPEAT);
   localparam logic [CW-1:0] HALF = CW'(REPEAT / 2);
`ifdef RWC_SCHED_UNSTABLE_EN
   localparam logic [CW-1:0] FULL = CW'(REPEAT);
`endif

   logic [CW-1:0] cnt [DATA_W];

   always_ff @(posedge clk) begin
      if (!w_resetn || clr) begin
         for (int i = 0; i < DATA_W; i++) cnt[i] <= '0;
      end else if (acc) begin
         for (int i = 0; i < DATA_W; i++) cnt[i] <= cnt[i] + CW'(bits[i]);
      end
   end

   always_comb begin
      maj = '0;
      for (int i = 0; i < DATA_W; i++) maj[i] = (cnt[i] > HALF);
   end

`ifdef RWC_SCHED_UNSTABLE_EN
   always_comb begin
      unstable = '0;
      for (int i = 0; i < DATA_W; i++) begin
         unstable[i] = (cnt[i] != '0) && (cnt[i] < FULL);
      end
   end
`endif

endmodule

// File: rtl/rwc_sched.sv
// Challenge scheduler: sweeps BRAM addresses, votes REPEAT rwc_ctrl runs per address.
// Optional unstable/clean-fail reporting under RWC_SCHED_UNSTABLE_EN.
module rwc_sched
   import rwc_pkg::*;
#(
   parameter int REPEAT  = 5,
   parameter int TIMEOUT = 64,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              w_resetn,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   num_addr,
   input  logic [DATA_W-1:0] cha_pattern,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              gen_enable,
   output logic [ADDR_W-1:0] gen_cha_addr,
   output logic [DATA_W-1:0] gen_cha_data,
   input  logic              gen_available,
   input  logic [DATA_W-1:0] gen_rsp_write,
   input  logic [DATA_W-1:0] gen_rsp_clean,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_data
`ifdef RWC_SCHED_UNSTABLE_EN
   ,
   output logic [DATA_W-1:0] rsp_unstable,
   output logic              clean_fail
`endif
);

   localparam int CW = cnt_w(REPEAT);
   localparam int TW = $clog2(TIMEOUT + 1);

   rwc_state_t state, state_nx;

   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic [DATA_W-1:0] pattern;
   logic [CW-1:0]     run;
   logic [TW-1:0]     timer;
   logic              err_q;

   logic take, hs, waiting, expired;
   logic vote_clr, vote_acc;

   assign take    = (state == S_IDLE) && start;
   assign hs      = (state == S_EMIT) && rsp_ready;
   assign waiting = state inside {S_ISSUE, S_WAIT_LO, S_WAIT_HI};
   assign expired = waiting && (timer == TW'(TIMEOUT - 1));

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (start) state_nx = (num_addr == '0) ? S_DONE : S_ISSUE;
         end
         S_ISSUE:   if (gen_available)  state_nx = S_WAIT_LO;
         S_WAIT_LO: if (!gen_available) state_nx = S_WAIT_HI;
         S_WAIT_HI: if (gen_available)  state_nx = S_ACCUM;
         S_ACCUM: begin
            state_nx = (run == CW'(REPEAT - 1)) ? S_EMIT : S_ISSUE;
         end
         S_EMIT: begin
            if (rsp_ready) begin
               state_nx = (remaining == (ADDR_W+1)'(1)) ? S_DONE : S_ISSUE;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         S_ERR:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      // a stalled handshake with rwc_ctrl aborts the whole sweep
      if (expired && state_nx == state) state_nx = S_ERR;
   end

   always_ff @(posedge clk) begin
      if (!w_resetn) begin
         state     <= S_IDLE;
         addr      <= '0;
         remaining <= '0;
         pattern   <= DATA_W'(CHALLENGE_CLEAR);
         run       <= '0;
         timer     <= '0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nx;
         timer <= (waiting && state_nx == state) ? timer + TW'(1) : '0;
         if (take) begin
            addr      <= base_addr;
            remaining <= num_addr;
            pattern   <= cha_pattern;
            run       <= '0;
            err_q     <= 1'b0;
         end
         if (state == S_ACCUM) run <= run + CW'(1);
         if (hs) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            run       <= '0;
         end
         if (state_nx == S_ERR) begin
            err_q <= 1'b1;
            run   <= '0;
         end
      end
   end

   assign vote_clr = take || hs || (state == S_ERR);
   assign vote_acc = (state == S_ACCUM);

   rwc_vote_acc #(
      .DATA_W (DATA_W),
      .REPEAT (REPEAT)
   ) u_vote (
      .clk      (clk),
      .w_resetn (w_resetn),
      .clr      (vote_clr),
      .acc      (vote_acc),
      .bits     (gen_rsp_write),
      .maj      (rsp_data)
`ifdef RWC_SCHED_UNSTABLE_EN
      ,
      .unstable (rsp_unstable)
`endif
   );

`ifdef RWC_SCHED_UNSTABLE_EN
   logic clean_q;

   always_ff @(posedge clk) begin
      if (!w_resetn) begin
         clean_q <= 1'b0;
      end else if (take) begin
         clean_q <= 1'b0;
      end else if (vote_acc && gen_rsp_clean != '0) begin
         clean_q <= 1'b1;
      end
   end

   assign clean_fail = clean_q;
`else
   logic unused_clean;
   assign unused_clean = ^gen_rsp_clean;
`endif

   assign busy         = state inside {S_ISSUE, S_WAIT_LO, S_WAIT_HI,
                                       S_ACCUM, S_EMIT};
   assign done         = (state == S_DONE);
   assign error        = err_q;
   assign gen_enable   = (state == S_WAIT_LO);
   assign gen_cha_addr = addr;
   assign gen_cha_data = pattern;
   assign rsp_valid    = (state == S_EMIT);
   assign rsp_addr     = addr;

endmodule

// File: tb/tb_rwc_sched.sv
// Directed bench for rwc_sched with a behavioural rwc_ctrl timing model.
module tb_rwc_sched;

   logic        clk = 1'b0;
   logic        w_resetn = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [10:0] num_addr = '0;
   logic [31:0] cha_pattern = '0;
   logic        busy, done, error, gen_enable;
   logic [9:0]  gen_cha_addr;
   logic [31:0] gen_cha_data;
   logic        gen_available;
   logic [31:0] gen_rsp_write;
   logic [31:0] gen_rsp_clean = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [9:0]  rsp_addr;
   logic [31:0] rsp_data;
`ifdef RWC_SCHED_UNSTABLE_EN
   logic [31:0] rsp_unstable;
   logic        clean_fail;
`endif

   int checks = 0;
   int errors = 0;

   // model control: 0 constant value, 1 three-of-five ones, 2 stuck available
   int          mode = 0;
   logic [31:0] mval = 32'hA5A5A5A5;

   logic        m_avail;
   logic [2:0]  m_cnt;
   logic [31:0] m_rsp;
   int          m_run;
   int          runs = 0;
   int          done_cnt = 0;
   logic [31:0] m_next;

   always #5 clk = ~clk;

   rwc_sched dut (
      .clk           (clk),
      .w_resetn      (w_resetn),
      .start         (start),
      .base_addr     (base_addr),
      .num_addr      (num_addr),
      .cha_pattern   (cha_pattern),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .gen_enable    (gen_enable),
      .gen_cha_addr  (gen_cha_addr),
      .gen_cha_data  (gen_cha_data),
      .gen_available (gen_available),
      .gen_rsp_write (gen_rsp_write),
      .gen_rsp_clean (gen_rsp_clean),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_addr      (rsp_addr),
      .rsp_data      (rsp_data)
`ifdef RWC_SCHED_UNSTABLE_EN
      ,
      .rsp_unstable  (rsp_unstable),
      .clean_fail    (clean_fail)
`endif
   );

   assign gen_available = m_avail;
   assign gen_rsp_write = m_rsp;

   always_comb begin
      m_next = mval;
      if (mode == 1) m_next = ((m_run % 5) < 3) ? 32'hFFFFFFFF : 32'h0;
   end

   // idle (available) plus four busy cycles per run
   always @(posedge clk) begin
      if (!w_resetn) begin
         m_avail <= 1'b1;
         m_cnt   <= '0;
         m_rsp   <= '0;
         m_run   <= 0;
      end else begin
         if (start) m_run <= 0;
         if (m_avail) begin
            if (gen_enable && mode != 2) begin
               m_avail <= 1'b0;
               m_cnt   <= 3'd4;
               runs    <= runs + 1;
            end
         end else if (m_cnt == 3'd1) begin
            m_avail <= 1'b1;
            m_rsp   <= m_next;
            m_run   <= m_run + 1;
         end else begin
            m_cnt <= m_cnt - 3'd1;
         end
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic do_start(input logic [9:0] b, input logic [10:0] n,
                           input logic [31:0] p);
      @(negedge clk);
      base_addr   = b;
      num_addr    = n;
      cha_pattern = p;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic get_rsp(input string nm, input logic [9:0] ea,
                          input logic [31:0] ed);
      int n = 0;
      while (!rsp_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!rsp_valid) begin
         errors++;
         $display("FAIL %s_valid: rsp_valid never rose within 300 cycles", nm);
      end else begin
         checks++;
         if (rsp_addr !== ea) begin
            errors++;
            $display("FAIL %s_addr: got %h expected %h", nm, rsp_addr, ea);
         end
         checks++;
         if (rsp_data !== ed) begin
            errors++;
            $display("FAIL %s_data: got %h expected %h", nm, rsp_data, ed);
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      w_resetn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, error, gen_enable, rsp_valid} !== 5'b0 ||
          gen_cha_addr !== 10'h0 || gen_cha_data !== 32'h0 ||
          rsp_addr !== 10'h0 || rsp_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: b%b d%b e%b g%b v%b a%h c%h ra%h rd%h",
                  busy, done, error, gen_enable, rsp_valid,
                  gen_cha_addr, gen_cha_data, rsp_addr, rsp_data);
      end
      w_resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int r0 = runs;
      int d0 = done_cnt;
      mode = 0;
      mval = 32'hA5A5A5A5;
      do_start(10'h010, 11'd3, 32'h0BADF00D);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy: got %b expected 1", busy);
      end
      checks++;
      if (gen_cha_data !== 32'h0BADF00D || gen_cha_addr !== 10'h010) begin
         errors++;
         $display("FAIL basic_cha: got %h/%h expected 010/0badf00d",
                  gen_cha_addr, gen_cha_data);
      end
      get_rsp("basic0", 10'h010, 32'hA5A5A5A5);
      get_rsp("basic1", 10'h011, 32'hA5A5A5A5);
      get_rsp("basic2", 10'h012, 32'hA5A5A5A5);
      repeat (3) @(negedge clk);
      checks++;
      if (done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL basic_done: got %0d pulses expected 1", done_cnt - d0);
      end
      checks++;
      if (runs - r0 != 15) begin
         errors++;
         $display("FAIL basic_runs: got %0d runs expected 15", runs - r0);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_majority;
      mode = 1;
      do_start(10'h020, 11'd1, 32'h11111111);
      get_rsp("major", 10'h020, 32'hFFFFFFFF);
`ifdef RWC_SCHED_UNSTABLE_EN
      checks++;
      if (rsp_unstable !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL major_unstable: got %h expected ffffffff", rsp_unstable);
      end
`endif
      repeat (3) @(negedge clk);
      mode = 0;
   endtask

   task automatic test_wrap;
      mode = 0;
      mval = 32'h12345678;
      do_start(10'h3FF, 11'd2, 32'h0);
      get_rsp("wrap0", 10'h3FF, 32'h12345678);
      get_rsp("wrap1", 10'h000, 32'h12345678);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_backpressure;
      int n = 0;
      int r0;
      logic bad = 1'b0;
      logic [9:0] a0;
      logic [31:0] dd;
      mode = 0;
      mval = 32'h5A5A0F0F;
      do_start(10'h100, 11'd2, 32'h0);
      while (!rsp_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      a0 = rsp_addr;
      dd = rsp_data;
      r0 = runs;
      repeat (20) begin
         @(negedge clk);
         if (!rsp_valid || rsp_addr !== a0 || rsp_data !== dd ||
             gen_enable) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL bp_stable: got unstable=%b expected 0", bad);
      end
      checks++;
      if (runs != r0) begin
         errors++;
         $display("FAIL bp_runs: got %0d new runs expected 0", runs - r0);
      end
      get_rsp("bp0", 10'h100, 32'h5A5A0F0F);
      get_rsp("bp1", 10'h101, 32'h5A5A0F0F);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_timeout;
      int n = 0;
      int hi = 0;
      int d0 = done_cnt;
      mode = 2;
      do_start(10'h000, 11'd1, 32'hCAFEF00D);
      while (!gen_enable && n < 50) begin
         @(negedge clk);
         n++;
      end
      while (gen_enable && hi < 200) begin
         hi++;
         @(negedge clk);
      end
      checks++;
      if (hi != 64) begin
         errors++;
         $display("FAIL to_cycles: got %0d cycles expected 64", hi);
      end
      checks++;
      if (error !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL to_flags: got err=%b busy=%b expected 1/0", error, busy);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done_cnt != d0 || error !== 1'b1) begin
         errors++;
         $display("FAIL to_sticky: got done=%0d err=%b expected 0/1",
                  done_cnt - d0, error);
      end
      mode = 0;
      mval = 32'h0F0F0F0F;
      do_start(10'h040, 11'd1, 32'h0);
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL to_clear: got %b expected 0", error);
      end
      get_rsp("to_rec", 10'h040, 32'h0F0F0F0F);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_num_zero;
      int r0 = runs;
      do_start(10'h050, 11'd0, 32'h0);
      checks++;
      if (done !== 1'b1 || gen_enable !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: got d=%b g=%b b=%b expected 1/0/0",
                  done, gen_enable, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || runs != r0) begin
         errors++;
         $display("FAIL zero_after: got d=%b runs=%0d expected 0/0",
                  done, runs - r0);
      end
   endtask

   task automatic test_reset_mid;
      int n = 0;
      mode = 0;
      mval = 32'h77777777;
      do_start(10'h155, 11'd1, 32'hDEADBEEF);
      while (!gen_enable && n < 50) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (gen_enable && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b1 || gen_cha_addr !== 10'h155 ||
          gen_cha_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL mid_pre: got b=%b a=%h c=%h expected 1/155/deadbeef",
                  busy, gen_cha_addr, gen_cha_data);
      end
      w_resetn = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, error, gen_enable, rsp_valid} !== 5'b0 ||
          gen_cha_addr !== 10'h0 || gen_cha_data !== 32'h0 ||
          rsp_addr !== 10'h0 || rsp_data !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset: b%b d%b e%b g%b v%b a%h c%h ra%h rd%h",
                  busy, done, error, gen_enable, rsp_valid,
                  gen_cha_addr, gen_cha_data, rsp_addr, rsp_data);
      end
      @(negedge clk);
      w_resetn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_majority();
      test_wrap();
      test_backpressure();
      test_timeout();
      test_num_zero();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rwc_sched.md
Name: rwc_sched

Overview:
- Challenge scheduler for the read-write-collision PUF generator (rwc_ctrl).
- Sweeps a host-specified range of BRAM addresses and launches REPEAT generator runs per address.
- Majority-votes the rsp_write results of those runs per bit and streams one 32-bit response per address over a valid/ready interface.
- Sits between the host/UART command layer and rwc_ctrl; it is the only driver of gen_enable, cha_addr and cha_data.

Parameters:
- REPEAT, 5, generator runs per address; odd, 1..15.
- TIMEOUT, 64, max cycles waiting for any gen_available edge before error.
- ADDR_W, 10, BRAM address width.
- DATA_W, 32, challenge/response width.

Ports:
- clk  in  1  clock
- w_resetn  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- base_addr  in  ADDR_W  first challenge address
- num_addr  in  ADDR_W+1  number of addresses (0..1024)
- cha_pattern  in  DATA_W  write pattern, latched at start
- busy  out  1  high from accepted start until DONE/ERR exit
- done  out  1  one-cycle pulse at sweep completion
- error  out  1  sticky timeout flag; cleared by next accepted start
- gen_enable  out  1  to rwc_ctrl gen_enable
- gen_cha_addr  out  ADDR_W  to rwc_ctrl cha_addr
- gen_cha_data  out  DATA_W  to rwc_ctrl cha_data
- gen_available  in  1  from rwc_ctrl available
- gen_rsp_write  in  DATA_W  from rwc_ctrl rsp_write
- gen_rsp_clean  in  DATA_W  from rwc_ctrl rsp_clean (used only by optional feature)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  downstream ready
- rsp_addr  out  ADDR_W  address of the current response
- rsp_data  out  DATA_W  majority-voted response

Behaviour:
- Reset: all outputs 0, state IDLE, per-bit counters cleared. gen_cha_data resets to 0; gen_cha_addr resets to 0.
- Reset mid-operation aborts at once; gen_enable drops in the same cycle the reset is registered.
- FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI, ACCUM, EMIT, DONE, ERR.
- IDLE:
  - On start, latch base_addr, num_addr and cha_pattern, clear error, assert busy.
  - If num_addr==0, go to DONE; otherwise go to ISSUE.
  - start in any other state is ignored.
- ISSUE: wait for gen_available==1, then assert gen_enable and go to WAIT_LO.
- WAIT_LO: hold gen_enable high until gen_available==0 is seen (rwc_ctrl's next-state register lags by one cycle), then drop gen_enable and go to WAIT_HI.
- WAIT_HI: wait for gen_available==1. At that point rsp_write/rsp_clean are stable; go to ACCUM.
- ACCUM (one cycle):
  - Each bit counter cnt[i] (width clog2(REPEAT+1)) increments if gen_rsp_write[i]==1; run counter increments.
  - If run==REPEAT, go to EMIT; otherwise go to ISSUE.
- EMIT:
  - rsp_valid=1; rsp_data[i] = (cnt[i] > REPEAT/2); rsp_addr = current address.
  - rsp_data and rsp_addr stay stable while rsp_valid && !rsp_ready.
  - On handshake: clear counters, address = address+1 mod 2^ADDR_W (1023 wraps to 0), remaining decrements; go to DONE if remaining==0, else ISSUE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Timeout:
  - One timer counts cycles in ISSUE, WAIT_LO and WAIT_HI; it clears on every state change.
  - At TIMEOUT it sets error and goes to ERR: gen_enable=0, busy=0, no done pulse, then IDLE next cycle.
  - Partial counters are discarded.
- gen_cha_addr and gen_cha_data are registered and stay constant for the whole of an address's REPEAT runs.
- Latency per address is roughly REPEAT×8 cycles plus backpressure.

Optional Feature:
- Macro RWC_SCHED_UNSTABLE_EN.
- When defined:
  - Adds output rsp_unstable[DATA_W]: bit i = 1 if 0 < cnt[i] < REPEAT.
  - Adds sticky output clean_fail, set when any ACCUM sees gen_rsp_clean != 0 and cleared on start.
- When undefined: neither port exists, gen_rsp_clean is unused, and no extra logic is built.

Decomposition:
- Package rwc_pkg: FSM state encoding, ADDR_W/DATA_W defaults, CHALLENGE_CLEAR constant (all zeros), and a cnt_w function.
- One sub-module, rwc_vote_acc: holds the DATA_W per-bit counters with clear/accumulate inputs and majority (plus optional unstable) outputs.

Test Plan (bench uses a behavioural rwc_ctrl model with 5-state timing):
- base=0x010, num=3, REPEAT=5, model always returns 0xA5A5A5A5 -> 3 responses, addrs 0x010/0x011/0x012, data 0xA5A5A5A5, done pulse, 15 gen_enable runs.
- Model returns 0xFFFFFFFF on 3 of 5 runs and 0 on 2 -> rsp_data 0xFFFFFFFF; with RWC_SCHED_UNSTABLE_EN, rsp_unstable 0xFFFFFFFF.
- base=0x3FF, num=2 -> addrs 0x3FF then 0x000 (wrap).
- rsp_ready held low 20 cycles in EMIT -> rsp_data/addr stable, no new gen_enable until handshake.
- Model never drops available -> error=1 after 64 cycles in WAIT_LO, busy=0, no done; next start clears error.
- num=0 -> done one cycle after start, no gen_enable; w_resetn low mid-WAIT_HI -> all outputs 0 next cycle.
